// File: rtl/key_cond_pkg.sv
// Shared types and defaults for the DE10-Lite key/switch front end.
// Imported by the per-key debouncer and the conditioner top level.
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } deb_state_t;

    // 20 ms at the 50 MHz board clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-FF synchroniser, debounce FSM and stability counter.
// accept_o is a registered one-cycle strobe when a press is confirmed.
module key_debounce
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic accept_o,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic       sync1_q;
    logic       sync2_q;
    logic       key_dn;
    deb_state_t state_q;
    deb_state_t state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic       accept_q;
    logic       accept_d;

    // Sync flops reset to the released level so reset never fakes a press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    assign key_dn = ~sync2_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_dn) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!key_dn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = HELD;
                    cnt_d    = '0;
                    accept_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!key_dn) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (key_dn) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            accept_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
        end
    end

    assign accept_o = accept_q;
    assign level_o  = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/key_input_conditioner.sv
// Key/switch front end for the code-cracker lock: debounced press pulses,
// chord rejection and a switch snapshot taken with each accepted press.
module key_input_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_KEYS          = 2,
    parameter int SW_W            = 10,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    input  logic [SW_W-1:0]   sw,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] key_level,
    output logic [SW_W-1:0]   sw_snap,
    output logic [SW_W-1:0]   sw_sync,
    output logic              chord_err
);

    logic [N_KEYS-1:0] accept;
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] busy_other;
    logic [SW_W-1:0]   sw_s1_q;
    logic [SW_W-1:0]   sw_s2_q;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] press_d;
    logic              chord_q;
    logic              chord_d;
    logic [SW_W-1:0]   snap_q;
    logic [SW_W-1:0]   snap_d;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i   (clk),
            .rst_i   (rst),
            .key_n_i (key_n[g]),
            .accept_o(accept[g]),
            .level_o (level[g])
        );
    end

    // A key conflicts if any other key is held or is accepting this cycle.
    always_comb begin
        busy_other = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            for (int j = 0; j < N_KEYS; j++) begin
                if (j != i && (level[j] || accept[j])) begin
                    busy_other[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        chord_d = |(accept & busy_other);
        press_d = accept & ~busy_other;
        snap_d  = snap_q;
        if (|press_d) begin
            snap_d = sw_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            press_q <= '0;
            chord_q <= 1'b0;
            snap_q  <= '0;
        end else begin
            sw_s1_q <= sw;
            sw_s2_q <= sw_s1_q;
            press_q <= press_d;
            chord_q <= chord_d;
            snap_q  <= snap_d;
        end
    end

    assign press_pulse = press_q;
    assign key_level   = level;
    assign sw_snap     = snap_q;
    assign sw_sync     = sw_s2_q;
    assign chord_err   = chord_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with an 8-cycle debounce window.
// Tick count 1 is the first edge that samples the new key level.
module tb_key_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_n;
    logic [9:0] sw;
    logic [1:0] press_pulse;
    logic [1:0] key_level;
    logic [9:0] sw_snap;
    logic [9:0] sw_sync;
    logic       chord_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    key_input_conditioner #(
        .N_KEYS(2),
        .SW_W(10),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_n(key_n),
        .sw(sw),
        .press_pulse(press_pulse),
        .key_level(key_level),
        .sw_snap(sw_snap),
        .sw_sync(sw_sync),
        .chord_err(chord_err)
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        key_n = 2'b11;
        sw = 10'h000;
        tick(3);
        total++;
        if (press_pulse !== 2'b00 || chord_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulse got=%b/%b want=00/0", press_pulse, chord_err);
        end
        total++;
        if (key_level !== 2'b00) begin
            bad++;
            $display("FAIL reset_level got=%b want=00", key_level);
        end
        total++;
        if (sw_snap !== 10'h000 || sw_sync !== 10'h000) begin
            bad++;
            $display("FAIL reset_sw got=%h/%h want=000/000", sw_snap, sw_sync);
        end
        rst = 1'b0;
        sw = 10'h2A5;
        tick(1);
        total++;
        if (sw_sync !== 10'h000) begin
            bad++;
            $display("FAIL sw_sync_1 got=%h want=000", sw_sync);
        end
        tick(1);
        total++;
        if (sw_sync !== 10'h2A5) begin
            bad++;
            $display("FAIL sw_sync_2 got=%h want=2a5", sw_sync);
        end
    endtask

    task automatic test_clean_press;
        int cnt;
        int first;
        int other;
        int last_hi;
        cnt = 0; first = 0; other = 0; last_hi = 0;
        key_n = 2'b10;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            if (press_pulse[0]) begin
                cnt++;
                first = c;
            end
            if (press_pulse[1] || chord_err) other++;
            if (c == 10 && key_level[0] !== 1'b0) other++;
            if (c == 11 && key_level[0] !== 1'b1) other++;
        end
        total++;
        if (cnt !== 1 || first !== 12) begin
            bad++;
            $display("FAIL clean_pulse got=%0d@%0d want=1@12", cnt, first);
        end
        total++;
        if (other !== 0) begin
            bad++;
            $display("FAIL clean_side got=%0d want=0", other);
        end
        total++;
        if (sw_snap !== 10'h2A5 || key_level !== 2'b01) begin
            bad++;
            $display("FAIL clean_snap got=%h/%b want=2a5/01", sw_snap, key_level);
        end
        key_n = 2'b11;
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            if (key_level[0]) last_hi = c;
            if (press_pulse !== 2'b00) other++;
        end
        total++;
        if (last_hi !== 10 || other !== 0) begin
            bad++;
            $display("FAIL release_level got=%0d/%0d want=10/0", last_hi, other);
        end
    endtask

    task automatic test_bounce;
        int cnt;
        int first;
        int early;
        cnt = 0; first = 0; early = 0;
        sw = 10'h1C3;
        key_n = 2'b10; tick(3);
        if (press_pulse !== 2'b00) early++;
        key_n = 2'b11; tick(1);
        key_n = 2'b10;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            if (press_pulse !== 2'b00 || key_level !== 2'b00) early++;
        end
        key_n = 2'b11; tick(1);
        if (press_pulse !== 2'b00) early++;
        key_n = 2'b10;
        for (int c = 1; c <= 30; c++) begin
            tick(1);
            if (press_pulse[0]) begin
                cnt++;
                first = c;
            end
        end
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL bounce_early got=%0d want=0", early);
        end
        total++;
        if (cnt !== 1 || first !== 12) begin
            bad++;
            $display("FAIL bounce_pulse got=%0d@%0d want=1@12", cnt, first);
        end
        total++;
        if (sw_snap !== 10'h1C3) begin
            bad++;
            $display("FAIL bounce_snap got=%h want=1c3", sw_snap);
        end
        key_n = 2'b11;
        tick(20);
    endtask

    task automatic test_chord;
        int p0;
        int p1;
        int ce;
        int ce_at;
        p0 = 0; p1 = 0; ce = 0; ce_at = 0;
        sw = 10'h0F0;
        key_n = 2'b10;
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            if (press_pulse[0]) p0++;
        end
        total++;
        if (p0 !== 1 || sw_snap !== 10'h0F0) begin
            bad++;
            $display("FAIL chord_first got=%0d/%h want=1/0f0", p0, sw_snap);
        end
        sw = 10'h333;
        key_n = 2'b00;
        p0 = 0;
        for (int c = 1; c <= 30; c++) begin
            tick(1);
            if (press_pulse[0]) p0++;
            if (press_pulse[1]) p1++;
            if (chord_err) begin
                ce++;
                ce_at = c;
            end
        end
        total++;
        if (p0 !== 0 || p1 !== 0) begin
            bad++;
            $display("FAIL chord_supp got=%0d/%0d want=0/0", p0, p1);
        end
        total++;
        if (ce !== 1 || ce_at !== 12) begin
            bad++;
            $display("FAIL chord_err got=%0d@%0d want=1@12", ce, ce_at);
        end
        total++;
        if (key_level !== 2'b11 || sw_snap !== 10'h0F0) begin
            bad++;
            $display("FAIL chord_state got=%b/%h want=11/0f0", key_level, sw_snap);
        end
        key_n = 2'b11;
        tick(20);
    endtask

    task automatic test_simultaneous;
        int pp;
        int ce;
        int ce_at;
        logic [1:0] lvl10;
        logic [1:0] lvl11;
        pp = 0; ce = 0; ce_at = 0;
        lvl10 = 2'bxx; lvl11 = 2'bxx;
        sw = 10'h155;
        key_n = 2'b00;
        for (int c = 1; c <= 25; c++) begin
            tick(1);
            if (press_pulse !== 2'b00) pp++;
            if (chord_err) begin
                ce++;
                ce_at = c;
            end
            if (c == 10) lvl10 = key_level;
            if (c == 11) lvl11 = key_level;
        end
        total++;
        if (pp !== 0) begin
            bad++;
            $display("FAIL simul_pulse got=%0d want=0", pp);
        end
        total++;
        if (ce !== 1 || ce_at !== 12) begin
            bad++;
            $display("FAIL simul_chord got=%0d@%0d want=1@12", ce, ce_at);
        end
        total++;
        if (lvl10 !== 2'b00 || lvl11 !== 2'b11) begin
            bad++;
            $display("FAIL simul_level got=%b/%b want=00/11", lvl10, lvl11);
        end
        total++;
        if (sw_snap !== 10'h0F0) begin
            bad++;
            $display("FAIL simul_snap got=%h want=0f0", sw_snap);
        end
        key_n = 2'b11;
        tick(20);
    endtask

    task automatic test_reset_mid;
        int cnt;
        int first;
        int dirty;
        cnt = 0; first = 0; dirty = 0;
        sw = 10'h3FF;
        key_n = 2'b01;
        tick(7);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick(1);
            if (press_pulse !== 2'b00 || key_level !== 2'b00 || chord_err !== 1'b0) dirty++;
            if (sw_snap !== 10'h000 || sw_sync !== 10'h000) dirty++;
        end
        total++;
        if (dirty !== 0) begin
            bad++;
            $display("FAIL rst_mid_outs got=%0d want=0", dirty);
        end
        rst = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick(1);
            if (press_pulse[1]) begin
                cnt++;
                first = c;
            end
        end
        total++;
        if (cnt !== 1 || first !== 12) begin
            bad++;
            $display("FAIL rst_mid_pulse got=%0d@%0d want=1@12", cnt, first);
        end
        total++;
        if (sw_snap !== 10'h3FF) begin
            bad++;
            $display("FAIL rst_mid_snap got=%h want=3ff", sw_snap);
        end
        key_n = 2'b11;
        tick(20);
    endtask

    task automatic test_release_glitch;
        int pp;
        int drop;
        pp = 0; drop = 0;
        key_n = 2'b10;
        tick(20);
        total++;
        if (key_level !== 2'b01) begin
            bad++;
            $display("FAIL glitch_held got=%b want=01", key_level);
        end
        key_n = 2'b11;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            if (!key_level[0]) drop++;
            if (press_pulse !== 2'b00) pp++;
        end
        key_n = 2'b10;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            if (!key_level[0]) drop++;
            if (press_pulse !== 2'b00) pp++;
        end
        total++;
        if (drop !== 0 || pp !== 0) begin
            bad++;
            $display("FAIL glitch_stable got=%0d/%0d want=0/0", drop, pp);
        end
        key_n = 2'b11;
        tick(20);
        total++;
        if (key_level !== 2'b00) begin
            bad++;
            $display("FAIL glitch_release got=%b want=00", key_level);
        end
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_chord;
        test_simultaneous;
        test_reset_mid;
        test_release_glitch;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
